// File: rtl/dilithium_params_pkg.sv
// Dilithium public-key constants (K = 6) shared by the t1 packer and unpacker,
// plus the unpacker state encoding.
package dilithium_params_pkg;

    localparam int K                     = 6;
    localparam int N                     = 256;
    localparam int SEEDBYTES             = 32;
    localparam int POLYT1_PACKEDBYTES    = 320;
    localparam int T1_BITS               = 10;
    localparam int CRYPTO_PUBLICKEYBYTES = SEEDBYTES + K * POLYT1_PACKEDBYTES;

    // One byte landing on a fill of at most 9 bits reaches bit 16.
    localparam int ACC_W = 17;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RHO  = 2'd1,
        ST_T1   = 2'd2,
        ST_DONE = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/polyt1_unpack_stream.sv
// Byte-to-10-bit regrouping for packed t1: a small LSB-first bit accumulator
// that takes bytes while under 10 bits are held and emits a coefficient otherwise.
module polyt1_unpack_stream
    import dilithium_params_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               byte_fire,
    output logic [T1_BITS-1:0] coeff,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic               coeff_fire
);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;

    // Accept and emit are mutually exclusive, so cnt stays within 0..17.
    assign in_ready    = enable && (cnt < CNT_W'(T1_BITS));
    assign coeff_valid = enable && (cnt >= CNT_W'(T1_BITS));
    assign coeff       = acc[T1_BITS-1:0];
    assign byte_fire   = in_ready && in_valid;
    assign coeff_fire  = coeff_valid && coeff_ready;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (byte_fire) begin
            acc <= acc | (ACC_W'(in_byte) << cnt);
            cnt <= cnt + CNT_W'(8);
        end else if (coeff_fire) begin
            acc <= acc >> T1_BITS;
            cnt <= cnt - CNT_W'(T1_BITS);
        end
    end

endmodule

// File: rtl/unpack_pk_stream.sv
// Streaming Dilithium public-key decoder: captures rho, then emits the K t1
// polynomials one indexed coefficient per handshake.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for start
// RHO     | capturing the 32 rho bytes
// T1      | regrouping t1 bytes into 10-bit coefficients
// DONE    | single-cycle done pulse, then back to IDLE
module unpack_pk_stream #(
    parameter int K                  = dilithium_params_pkg::K,
    parameter int SEEDBYTES          = dilithium_params_pkg::SEEDBYTES,
    parameter int POLYT1_PACKEDBYTES = dilithium_params_pkg::POLYT1_PACKEDBYTES,
    parameter int COEFF_W            = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [255:0]         rho,
    output logic                 rho_valid,
    output logic [COEFF_W-1:0]   coeff,
    output logic [2:0]           coeff_poly,
    output logic [7:0]           coeff_idx,
    output logic                 coeff_valid,
    input  logic                 coeff_ready,
    output logic                 busy,
    output logic                 done
);

    import dilithium_params_pkg::*;

    localparam int COEFFS_PER_POLY = POLYT1_PACKEDBYTES * 8 / T1_BITS;

    unpack_state_t state_q, state_d;

    logic               start_acc;
    logic               rho_fire;
    logic               rho_last;
    logic               coeff_last;
    logic [4:0]         byte_cnt;
    logic               t1_in_ready;
    logic               t1_byte_fire;
    logic               t1_coeff_fire;
    logic [T1_BITS-1:0] t1_coeff;

    assign start_acc  = (state_q == ST_IDLE) && start;
    assign rho_fire   = (state_q == ST_RHO) && in_valid;
    assign rho_last   = rho_fire && (byte_cnt == 5'(SEEDBYTES - 1));
    assign coeff_last = t1_coeff_fire
                        && (coeff_poly == 3'(K - 1))
                        && (coeff_idx == 8'(COEFFS_PER_POLY - 1));

    polyt1_unpack_stream u_t1 (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_acc),
        .enable      (state_q == ST_T1),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (t1_in_ready),
        .byte_fire   (t1_byte_fire),
        .coeff       (t1_coeff),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .coeff_fire  (t1_coeff_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start)      state_d = ST_RHO;
            ST_RHO:  if (rho_last)   state_d = ST_T1;
            ST_T1:   if (coeff_last) state_d = ST_DONE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rho <= '0;
        end else if (rho_fire) begin
            rho[{byte_cnt, 3'b000} +: 8] <= in_byte;
        end
    end

    // Poly index goes back to 0 after the final coefficient so it never shows K.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            byte_cnt   <= '0;
            rho_valid  <= 1'b0;
            coeff_poly <= '0;
            coeff_idx  <= '0;
        end else begin
            if (rho_fire) begin
                byte_cnt <= byte_cnt + 5'd1;
            end
            if (rho_last) begin
                rho_valid <= 1'b1;
            end
            if (t1_coeff_fire) begin
                coeff_idx <= coeff_idx + 8'd1;
                if (coeff_last) begin
                    coeff_poly <= '0;
                end else if (coeff_idx == 8'(COEFFS_PER_POLY - 1)) begin
                    coeff_poly <= coeff_poly + 3'd1;
                end
            end
        end
    end

    assign in_ready = (state_q == ST_RHO) || t1_in_ready;
    assign coeff    = {{(COEFF_W - T1_BITS){1'b0}}, t1_coeff};
    assign busy     = (state_q == ST_RHO) || (state_q == ST_T1);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_unpack_pk_stream.sv
// Directed bench for unpack_pk_stream: keys are packed by an in-bench bit-level
// packer and streamed in with and without handshake stalls.
module tb_unpack_pk_stream;

    localparam int PKB    = 1952;
    localparam int NCOEF  = 1536;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] rho;
    logic         rho_valid;
    logic [31:0]  coeff;
    logic [2:0]   coeff_poly;
    logic [7:0]   coeff_idx;
    logic         coeff_valid;
    logic         coeff_ready;
    logic         busy;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]   key   [PKB];
    logic [9:0]   coef  [NCOEF];
    logic [255:0] exp_rho;
    logic [9:0]   hand  [8]  = '{10'd1, 10'd1, 10'd1, 10'd1, 10'd1023, 10'd0, 10'd0, 10'd0};
    logic [7:0]   hbyte [10] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h00, 8'hFF, 8'h03, 8'h00, 8'h00, 8'h00};

    unpack_pk_stream dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rho         (rho),
        .rho_valid   (rho_valid),
        .coeff       (coeff),
        .coeff_poly  (coeff_poly),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .coeff_ready (coeff_ready),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},    in_ready,    0);
        chk({tag, "_coeff_valid"}, coeff_valid, 0);
        chk({tag, "_rho"},         rho,         0);
        chk({tag, "_rho_valid"},   rho_valid,   0);
        chk({tag, "_coeff"},       coeff,       0);
        chk({tag, "_coeff_poly"},  coeff_poly,  0);
        chk({tag, "_coeff_idx"},   coeff_idx,   0);
        chk({tag, "_busy"},        busy,        0);
        chk({tag, "_done"},        done,        0);
    endtask

    // Reference packer: t1 bit k of the stream is bit (k mod 10) of coefficient k/10.
    task automatic make_key(input bit directed);
        for (int i = 0; i < NCOEF; i++) coef[i] = 10'($urandom);
        if (directed) for (int i = 0; i < 8; i++) coef[i] = hand[i];
        for (int i = 0; i < 32; i++) begin
            key[i] = 8'($urandom);
            exp_rho[8*i +: 8] = key[i];
        end
        for (int b = 0; b < PKB - 32; b++) begin
            logic [7:0] v;
            v = '0;
            for (int i = 0; i < 8; i++) begin
                int bp;
                bp   = 8 * b + i;
                v[i] = coef[bp / 10][bp % 10];
            end
            key[32 + b] = v;
        end
        if (directed) for (int i = 0; i < 10; i++) key[32 + i] = hbyte[i];
    endtask

    task automatic run_key(input bit stalls, input bit poke_start, input int abort_at, input bit directed);
        int bptr  = 0;
        int cidx  = 0;
        int cyc   = 0;
        bit poked = 0;
        bit fi, fc;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_after_start", in_ready, 1);
        chk("rho_valid_cleared", rho_valid, 0);
        chk("busy_after_start", busy, 1);
        while (cyc < 20000) begin
            if (abort_at >= 0 && bptr == abort_at) return;
            if (done) break;
            chk("ready_valid_exclusive", in_ready & coeff_valid, 0);
            chk("rho_valid_timing", rho_valid, bptr >= 32);
            if (coeff_valid) begin
                chk("coeff_value", coeff, coef[cidx]);
                chk("coeff_poly", coeff_poly, cidx / 256);
                chk("coeff_idx", coeff_idx, cidx % 256);
                if (directed && cidx < 8) chk("directed_coeff", coeff, hand[cidx]);
            end
            if (poke_start && !poked && cidx == 700) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            in_valid    = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_byte     = (bptr < PKB) ? key[bptr] : 8'h00;
            coeff_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            fi = in_valid && in_ready;
            fc = coeff_valid && coeff_ready;
            @(posedge clk);
            if (fi) bptr++;
            if (fc) cidx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("busy_low_at_done", busy, 0);
        chk("in_ready_low_at_done", in_ready, 0);
        chk("byte_handshakes", 256'(bptr), PKB);
        chk("coeff_handshakes", 256'(cidx), NCOEF);
        chk("rho_value", rho, exp_rho);
        chk("rho_valid_at_done", rho_valid, 1);
        in_valid    = 1'b0;
        coeff_ready = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("rho_valid_held", rho_valid, 1);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_byte     = 8'h00;
        coeff_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        make_key(1'b1);
        run_key(1'b0, 1'b0, -1, 1'b1);
        run_key(1'b1, 1'b1, -1, 1'b1);

        make_key(1'b0);
        run_key(1'b1, 1'b0, 500, 1'b0);
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset("abort");
        rst = 1'b0;
        run_key(1'b0, 1'b0, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
